// File: rtl/reduction_pipe_csg_if.sv
// reduction_pipe_csg_if: bundles the control, data and result signals of the
// reduction pipe. The master side drives vectors and controls; the slave side
// (the pipe itself) returns the results.
interface reduction_pipe_csg_if #(
  parameter int DIMENSION = 3,
  parameter int CHANNELS  = 1
);
  logic                          en;
  logic                          flush;
  logic                          in_valid;
  logic [CHANNELS*DIMENSION-1:0] in;
  logic [DIMENSION-1:0]          mask;
  logic [1:0]                    mode;
  logic                          out_valid;
  logic [CHANNELS-1:0]           out;
  logic [CHANNELS-1:0]           out_rise;

  modport master (
    output en, flush, in_valid, in, mask, mode,
    input  out_valid, out, out_rise
  );

  modport slave (
    input  en, flush, in_valid, in, mask, mode,
    output out_valid, out, out_rise
  );
endinterface

// File: rtl/reduction_pipe_csg.sv
// reduction_pipe_csg: two-stage pipelined multi-channel masked bit reduction
// (AND / OR / XOR / NOR) with enable, flush and an optional per-channel
// rising-edge pulse. Define REDUCTION_PIPE_CSG_EDGE_EN to build the edge
// history (prev) and out_rise logic; otherwise out_rise is tied to 0.
module reduction_pipe_csg #(
  parameter int DIMENSION = 3,
  parameter int CHANNELS  = 1,
  parameter int CHUNK     = 4
) (
  input logic               clk,
  input logic               rst_n,
  reduction_pipe_csg_if.slave bus
);

  localparam int NCHUNK = (DIMENSION + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;

  // Operator class carried down the pipe; NOR travels as OR plus an invert flag.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10
  } op_t;

  function automatic logic reduce_chunk(input logic [CHUNK-1:0] v, input op_t op);
    case (op)
      OP_AND:  reduce_chunk = &v;
      OP_OR:   reduce_chunk = |v;
      default: reduce_chunk = ^v;
    endcase
  endfunction

  function automatic logic reduce_parts(input logic [NCHUNK-1:0] v, input op_t op);
    case (op)
      OP_AND:  reduce_parts = &v;
      OP_OR:   reduce_parts = |v;
      default: reduce_parts = ^v;
    endcase
  endfunction

  op_t                        cls_d;
  logic                       inv_d;
  logic                       ident;
  logic [CHANNELS*PADW-1:0]   padded;
  logic [CHANNELS*NCHUNK-1:0] part_d;

  logic                       valid_a;
  logic [CHANNELS*NCHUNK-1:0] part_a;
  op_t                        op_a;
  logic                       inv_a;

  logic [CHANNELS-1:0]        res_b;

  // Decode the incoming mode into an operator class, invert flag and identity bit.
  always_comb begin
    cls_d = (bus.mode == 2'b11) ? OP_OR : op_t'(bus.mode);
    inv_d = (bus.mode == 2'b11);
    ident = (cls_d == OP_AND);
  end

  // Substitute the identity for masked and padding bits, then reduce each chunk.
  always_comb begin
    padded = {(CHANNELS*PADW){ident}};
    part_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < DIMENSION; i++) begin
        padded[c*PADW + i] = bus.mask[i] ? bus.in[c*DIMENSION + i] : ident;
      end
      for (int k = 0; k < NCHUNK; k++) begin
        part_d[c*NCHUNK + k] = reduce_chunk(padded[c*PADW + k*CHUNK +: CHUNK], cls_d);
      end
    end
  end

  // Stage A registers: chunk partials plus the operator and valid that go with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      part_a  <= '0;
      op_a    <= OP_AND;
      inv_a   <= 1'b0;
    end else if (bus.flush) begin
      valid_a <= 1'b0;
      part_a  <= '0;
      op_a    <= OP_AND;
      inv_a   <= 1'b0;
    end else if (bus.en) begin
      valid_a <= bus.in_valid;
      part_a  <= part_d;
      op_a    <= cls_d;
      inv_a   <= inv_d;
    end
  end

  // Combine the partials of each channel and apply the NOR inversion.
  always_comb begin
    res_b = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      res_b[c] = reduce_parts(part_a[c*NCHUNK +: NCHUNK], op_a) ^ inv_a;
    end
  end

  // Stage B registers: out only changes on a valid result, bubbles leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
    end else if (bus.en) begin
      bus.out_valid <= valid_a;
      if (valid_a) begin
        bus.out <= res_b;
      end
    end
  end

`ifdef REDUCTION_PIPE_CSG_EDGE_EN
  logic [CHANNELS-1:0] prev;

  // Edge history: pulse out_rise on a 0->1 result, updating prev only on valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev         <= '0;
      bus.out_rise <= '0;
    end else if (bus.flush) begin
      prev         <= '0;
      bus.out_rise <= '0;
    end else if (bus.en) begin
      if (valid_a) begin
        bus.out_rise <= res_b & ~prev;
        prev         <= res_b;
      end else begin
        bus.out_rise <= '0;
      end
    end
  end
`else
  assign bus.out_rise = '0;
`endif

endmodule

// File: tb/tb_reduction_pipe_csg.sv
// tb_reduction_pipe_csg: drives directed and random vectors into a
// 9-bit / 2-channel / 4-bit-chunk pipe and compares every cycle against a
// reference model that computes each result from bit counts.
module tb_reduction_pipe_csg;

  localparam int DIMENSION = 9;
  localparam int CHANNELS  = 2;
  localparam int CHUNK     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  reduction_pipe_csg_if #(.DIMENSION(DIMENSION), .CHANNELS(CHANNELS)) bus ();

  reduction_pipe_csg #(
    .DIMENSION(DIMENSION),
    .CHANNELS (CHANNELS),
    .CHUNK    (CHUNK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic                m_stage_valid;
  logic [CHANNELS-1:0] m_stage_res;
  logic                m_valid;
  logic [CHANNELS-1:0] m_out;
  logic [CHANNELS-1:0] m_rise;
  logic [CHANNELS-1:0] m_prev;

  function automatic logic [CHANNELS-1:0] refReduce(
    input logic [CHANNELS*DIMENSION-1:0] v,
    input logic [DIMENSION-1:0]          m,
    input logic [1:0]                    md
  );
    logic [DIMENSION-1:0] ch;
    int ones;
    int part;
    logic [CHANNELS-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ch   = v[c*DIMENSION +: DIMENSION];
      ones = $countones(ch & m);
      part = $countones(m);
      case (md)
        2'b00:   r[c] = (ones == part);
        2'b01:   r[c] = (ones != 0);
        2'b10:   r[c] = (ones % 2) == 1;
        default: r[c] = (ones == 0);
      endcase
    end
    return r;
  endfunction

  task automatic modelReset();
    m_stage_valid = 1'b0;
    m_stage_res   = '0;
    m_valid       = 1'b0;
    m_out         = '0;
    m_rise        = '0;
    m_prev        = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(bus.out_valid), 32'(m_valid));
    checkOutput("out",       32'(bus.out),       32'(m_out));
    checkOutput("out_rise",  32'(bus.out_rise),  32'(m_rise));
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic applyStimulus(
    input logic                          e,
    input logic                          f,
    input logic                          v,
    input logic [CHANNELS*DIMENSION-1:0] data,
    input logic [DIMENSION-1:0]          m,
    input logic [1:0]                    md
  );
    bus.en       = e;
    bus.flush    = f;
    bus.in_valid = v;
    bus.in       = data;
    bus.mask     = m;
    bus.mode     = md;
    @(posedge clk);
    if (f) begin
      modelReset();
    end else if (e) begin
      m_valid = m_stage_valid;
      if (m_stage_valid) begin
`ifdef REDUCTION_PIPE_CSG_EDGE_EN
        m_rise = m_stage_res & ~m_prev;
`else
        m_rise = '0;
`endif
        m_prev = m_stage_res;
        m_out  = m_stage_res;
      end else begin
        m_rise = '0;
      end
      m_stage_valid = v;
      m_stage_res   = refReduce(data, m, md);
    end
    #1;
    checkAll();
  endtask

  localparam logic [DIMENSION-1:0] ALL = {DIMENSION{1'b1}};
  localparam logic [CHANNELS*DIMENSION-1:0] ONES = {(CHANNELS*DIMENSION){1'b1}};

  initial begin
    bus.en       = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in       = '0;
    bus.mask     = '0;
    bus.mode     = 2'b00;
    modelReset();
    #12;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    // XOR across a padded last chunk, then with the top bit masked off.
    applyStimulus(1, 0, 1, {9'h007, 9'h101}, ALL, 2'b10);
    applyStimulus(1, 0, 1, {9'h007, 9'h101}, 9'h0FF, 2'b10);
    checkOutput("xor_full", 32'(bus.out), 32'h2);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    checkOutput("xor_mask8", 32'(bus.out), 32'h3);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);

    // All-masked vectors with the mode changing every cycle.
    applyStimulus(1, 0, 1, 18'h15A5A, '0, 2'b11);
    applyStimulus(1, 0, 1, 18'h15A5A, '0, 2'b01);
    applyStimulus(1, 0, 1, 18'h15A5A, '0, 2'b00);
    applyStimulus(1, 0, 1, 18'h15A5A, '0, 2'b10);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);

    // Hold the pipe for three cycles after accepting a vector.
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(0, 0, 1, '0, ALL, 2'b01);
    applyStimulus(0, 0, 1, '0, ALL, 2'b01);
    applyStimulus(0, 0, 1, '0, ALL, 2'b01);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);

    // AND results 0,1,1,0,1 for the edge pulse.
    applyStimulus(1, 0, 1, '0,   ALL, 2'b00);
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 1, '0,   ALL, 2'b00);
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);

    // Flush between the second and third vector; the input during flush is dropped.
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 1, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);

    // Asynchronous reset with two vectors in flight.
    applyStimulus(1, 0, 1, ONES, ALL, 2'b00);
    applyStimulus(1, 0, 1, ONES, ALL, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);
    applyStimulus(1, 0, 0, '0, ALL, 2'b00);

    // Random traffic with occasional stalls and flushes.
    for (int n = 0; n < 400; n++) begin
      logic                          e;
      logic                          f;
      logic                          v;
      logic [CHANNELS*DIMENSION-1:0] data;
      logic [DIMENSION-1:0]          m;
      logic [1:0]                    md;
      e    = ($urandom % 6) != 0;
      f    = ($urandom % 20) == 0;
      v    = ($urandom % 4) != 0;
      data = (CHANNELS*DIMENSION)'($urandom);
      if (($urandom % 3) == 0) data = data | ((CHANNELS*DIMENSION)'($urandom) & ONES);
      m    = (($urandom % 4) == 0) ? ALL : DIMENSION'($urandom);
      md   = 2'($urandom);
      applyStimulus(e, f, v, data, m, md);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
